regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port integer register file with a built-in scoreboard for the pipelined core. It replaces the single-write, two-read register file in the decode/writeback boundary. It supports N read ports, M write ports, same-cycle write-to-read bypass, a deterministic reset image and per-register busy tracking for in-flight producers. Decode reads operands and marks destinations busy; writeback ports update data and clear busy.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 4
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..2)
- SP_INIT, 32'h0000FFFF, reset value of register 2
- GP_INIT, 32'h00004FFF, reset value of register 3

Ports (AW = $clog2(NREGS)):
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- raddr  in  NRD*AW  read addresses; port i occupies [i*AW +: AW]
- rdata  out  NRD*XLEN  read data, combinational
- rbusy  out  NRD  1 = the register read on port i has a pending producer that is not being written this cycle
- wen  in  NWR  per-port write enable
- waddr  in  NWR*AW  write addresses
- wdata  in  NWR*XLEN  write data
- wclr  in  NWR  1 = this write also clears the register's busy bit
- iss_en  in  1  mark a destination busy
- iss_addr  in  AW  destination register to mark busy
- busy_vec  out  NREGS  raw scoreboard state; bit 0 is always 0

## Operation
- Register 0 is hardwired to zero:
  - writes to it are dropped;
  - reads return 0;
  - issuing to it has no effect on the scoreboard.
- Reset: on a rising edge with reset=1, all registers are set to 0 except reg2=SP_INIT and reg3=GP_INIT, and busy_vec becomes all 0. Reset overrides every write and issue in the same cycle.
- Write: on a rising edge with wen[j]=1 and waddr[j]!=0, regs[waddr[j]] <= wdata[j].
  - If two ports target the same address in the same cycle, the higher port index wins.
- Read data for port i, in priority order:
  1. If raddr[i]==0, the result is 0.
  2. Otherwise, if any wen[j]=1 with waddr[j]==raddr[i], the result is wdata of the highest such j (bypass).
  3. Otherwise, the result is the stored register value.
- Busy bit update, per register r!=0, evaluated on each rising edge:
  - It is set if iss_en=1 and iss_addr==r.
  - Otherwise it is cleared if any port j has wen[j]=1, wclr[j]=1 and waddr[j]==r.
  - Otherwise it holds.
  - Simultaneous issue and clear on the same register: set wins, because a new producer supersedes the old one.
- rbusy[i] = busy_vec[raddr[i]] AND NOT (a bypassing write with wclr=1 to raddr[i] this cycle). rbusy[i] is 0 when raddr[i]==0.
- A write with wclr=0 updates data but leaves the busy bit unchanged. This is used for speculative or partial results.

## Timing
- Read latency is 0 cycles: rdata and rbusy are combinational from raddr, the write ports and the state.
- Write latency is 1 cycle: data is visible in storage after the edge, and already visible via bypass in the same cycle.
- The scoreboard is updated at the edge. iss_en in cycle t gives rbusy=1 from cycle t+1.
- After reset deasserts:
  - rdata reads 0 for every register except reg2 and reg3;
  - busy_vec is 0;
  - rbusy is 0.
- Reset asserted mid-operation discards pending writes, issues and busy bits in that same cycle.
- There is no internal handshake and no stall; the producer is responsible for not issuing more than once per cycle.

## Structure
- Shared include file rv_defs.vh holds:
  - ABI register index constants (REG_ZERO, REG_SP=2, REG_GP=3);
  - default XLEN;
  - SP/GP reset constants reused by the core top.
- Sub-module regfile_scoreboard (NREGS, NWR) holds the busy vector, its set/clear priority logic and the per-port rbusy masking.
- The storage array, write-priority logic and bypass muxes stay in regfile_mp, generated with loops over NRD and NWR.

## Test plan
- Reset image: assert reset for 1 cycle with wen=1, waddr=5, wdata=0xDEAD. Then read reg2 = 0x0000FFFF, reg3 = 0x00004FFF, reg5 = 0, busy_vec = 0.
- Bypass and x0: write reg7 = 0x12345678 while raddr0=7 in the same cycle, so rdata0 = 0x12345678 before the edge. A write of 0xFFFF to reg0 leaves rdata for reg0 = 0.
- Dual-write conflict (NWR=2): port0 writes reg9=0x1 and port1 writes reg9=0x2 in the same cycle. The bypass read gives 0x2 and the stored value after the edge is 0x2.
- Scoreboard lifecycle:
  - iss_en with iss_addr=4 → rbusy for reg4 = 1 next cycle.
  - A write to reg4 with wclr=1 → rbusy = 0 in that same cycle via the mask, and busy_vec[4] = 0 after the edge.
- Set-wins race: reg6 is busy; in one cycle issue reg6 and write reg6 with wclr=1. After the edge busy_vec[6] = 1 and the data is updated.
- Parameter sweep: with NREGS=16, NRD=3, NWR=2, XLEN=64, all three ports read distinct registers concurrently with correct values. iss_addr=0 never sets busy_vec[0].

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the integer register file and the core top.
//   ABI register indices, default data width and the SP/GP reset image.
package regfile_mp_pkg;

    localparam int unsigned XLEN_DEF = 32;

    // ABI register indices
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 2;
    localparam int unsigned REG_GP   = 3;

    // Reset image for stack and global pointers
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_FFFF;
    localparam logic [31:0] GP_INIT_DEF = 32'h0000_4FFF;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy-bit scoreboard for in-flight producers.
//   clk, reset      : clock, synchronous active-high reset
//   wen/waddr/wclr  : writeback ports; wclr clears the destination busy bit
//   iss_en/iss_addr : decode marks a destination busy (wins over a clear)
//   raddr           : read addresses to report busy status for
//   rbusy           : per read port, busy and not cleared by a write this cycle
//   busy_vec        : raw scoreboard state, bit 0 always 0
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR-1:0]    wclr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;

    // Clears first, then the issue set, so a new producer supersedes the old one
    always_comb begin
        busy_nxt = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j] && wclr[j]) begin
                busy_nxt[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[REG_ZERO] = 1'b0;
    end

    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy_vec = busy_q;

    // Busy status per read port, masked by a clearing write landing this cycle
    for (genvar i = 0; i < NRD; i++) begin : g_rbusy
        logic [AW-1:0] ra;
        logic          clr_hit;

        assign ra = raddr[i*AW +: AW];

        always_comb begin
            clr_hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && wclr[j] && (waddr[j*AW +: AW] == ra)) begin
                    clr_hit = 1'b1;
                end
            end
        end

        assign rbusy[i] = busy_q[ra] && !clr_hit && (ra != AW'(REG_ZERO));
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and scoreboard.
//   clk, reset            : clock, synchronous active-high reset
//   raddr/rdata/rbusy     : NRD combinational read ports with busy status
//   wen/waddr/wdata/wclr  : NWR write ports; higher index wins on conflict
//   iss_en/iss_addr       : mark a destination register busy
//   busy_vec              : raw scoreboard state
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned NRD     = 2,
    parameter int unsigned NWR     = 1,
    parameter logic [31:0] SP_INIT = SP_INIT_DEF,
    parameter logic [31:0] GP_INIT = GP_INIT_DEF,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NWR-1:0]      wclr,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] regs [NREGS];

    // Storage; later ports overwrite earlier ones so the highest index wins
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            regs[REG_SP] <= XLEN'(SP_INIT);
            regs[REG_GP] <= XLEN'(GP_INIT);
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (waddr[j*AW +: AW] != AW'(REG_ZERO))) begin
                    regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Read muxes: x0 forces zero, else highest matching write port bypasses
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = raddr[i*AW +: AW];

        always_comb begin
            rd = regs[ra];
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (waddr[j*AW +: AW] == ra)) begin
                    rd = wdata[j*XLEN +: XLEN];
                end
            end
            if (ra == AW'(REG_ZERO)) begin
                rd = '0;
            end
        end

        assign rdata[i*XLEN +: XLEN] = rd;
    end

    regfile_mp_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wen      (wen),
        .waddr    (waddr),
        .wclr     (wclr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .raddr    (raddr),
        .rbusy    (rbusy),
        .busy_vec (busy_vec)
    );

endmodule
